lifo_stack: RTL and testbench



---
 rtl/lifo_stack.sv | 91 +++++++++
 tb/tb_lifo_stack.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// Parameterised synchronous LIFO stack with registered completion pulse.
// Define STACK_ERR_EN to add the sticky overflow/underflow flag output err.
`timescale 1ns/1ps
module lifo_stack #(
  parameter int STACKDATA = 32,
  parameter int STACKSIZE = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           trigger,
  input  logic [STACKDATA-1:0]           write_value,
  output logic [STACKDATA-1:0]           read_value,
  output logic                           done_out,
  output logic [$clog2(STACKSIZE):0]     count,
  output logic                           empty,
  output logic                           full
`ifdef STACK_ERR_EN
  ,
  output logic                           err
`endif
);

  localparam int AW = $clog2(STACKSIZE);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(STACKSIZE);

  logic [STACKDATA-1:0] mem [STACKSIZE];

  logic [CW-1:0]        count_q, count_d;
  logic [STACKDATA-1:0] rd_q, rd_d;
  logic                 done_q, done_d;
  logic                 do_push, do_pop;
  logic [AW-1:0]        wr_addr, pop_addr;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign wr_addr  = count_q[AW-1:0];
  assign pop_addr = AW'(count_q - 1'b1);
  assign do_push  = trigger & push & ~full;
  assign do_pop   = trigger & ~push & ~empty;

  always_comb begin
    count_d = count_q;
    rd_d    = rd_q;
    done_d  = trigger;
    if (do_push) begin
      count_d = count_q + 1'b1;
    end else if (do_pop) begin
      count_d = count_q - 1'b1;
      rd_d    = mem[pop_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  // Storage is deliberately left out of reset; only entries below count matter.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_addr] <= write_value;
  end

`ifdef STACK_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (trigger & ((push & full) | (~push & empty)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

  assign count      = count_q;
  assign read_value = rd_q;
  assign done_out   = done_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed test-plan steps followed by
// randomized traffic compared against a queue-based stack model.
`timescale 1ns/1ps
module tb_lifo_stack;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic          trigger;
  logic [DW-1:0] write_value;
  logic [DW-1:0] read_value;
  logic          done_out;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
`ifdef STACK_ERR_EN
  logic          err;
`endif

  lifo_stack #(.STACKDATA(DW), .STACKSIZE(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .trigger     (trigger),
    .write_value (write_value),
    .read_value  (read_value),
    .done_out    (done_out),
    .count       (count),
    .empty       (empty),
    .full        (full)
`ifdef STACK_ERR_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] m_q [$];
  logic [DW-1:0] exp_rd;
  logic          exp_done;
  logic          exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_q.delete();
    exp_rd   = '0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic model_edge(input logic t, input logic p, input logic [DW-1:0] v);
    exp_done = t;
    if (t) begin
      if (p) begin
        if (m_q.size() < DEPTH) m_q.push_back(v);
        else exp_err = 1'b1;
      end else begin
        if (m_q.size() > 0) exp_rd = m_q.pop_back();
        else exp_err = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".done"},  64'(done_out),   64'(exp_done));
    chk({tag, ".count"}, 64'(count),      64'(m_q.size()));
    chk({tag, ".rd"},    64'(read_value), 64'(exp_rd));
    chk({tag, ".empty"}, 64'(empty),      64'(m_q.size() == 0));
    chk({tag, ".full"},  64'(full),       64'(m_q.size() == DEPTH));
`ifdef STACK_ERR_EN
    chk({tag, ".err"},   64'(err),        64'(exp_err));
`endif
  endtask

  task automatic step(input logic t, input logic p, input logic [DW-1:0] v, input string tag);
    trigger     = t;
    push        = p;
    write_value = v;
    @(posedge clk);
    model_edge(t, p, v);
    #1;
    check_all(tag);
  endtask

  task automatic pop_expect(input logic [DW-1:0] v, input string tag);
    step(1'b1, 1'b0, '0, tag);
    chk({tag, ".value"}, 64'(read_value), 64'(v));
    chk({tag, ".pulse"}, 64'(done_out), 64'd1);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    model_clear();
    #1;
    check_all(tag);
    #2;
    rst     = 1'b0;
    trigger = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; push = 1'b0; trigger = 1'b0; write_value = '0;
    model_clear();
    #12;
    check_all("por");
    rst = 1'b0;

    step(1'b1, 1'b0, '0, "underflow");
    chk("underflow.cnt0", 64'(count), 64'd0);
    async_reset("rst_midcycle");
    chk("rst_midcycle.done0", 64'(done_out), 64'd0);

    step(1'b1, 1'b1, 32'h11, "lifo_push1");
    step(1'b1, 1'b1, 32'h22, "lifo_push2");
    step(1'b1, 1'b1, 32'h33, "lifo_push3");
    chk("lifo.count3", 64'(count), 64'd3);
    pop_expect(32'h33, "lifo_pop1");
    pop_expect(32'h22, "lifo_pop2");
    pop_expect(32'h11, "lifo_pop3");
    chk("lifo.empty", 64'(empty), 64'd1);
    step(1'b0, 1'b1, 32'hDEAD, "idle");

    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 32'(i), "full_push");
    chk("full.flag", 64'(full), 64'd1);
    step(1'b1, 1'b1, 32'd5, "overflow");
    chk("overflow.cnt", 64'(count), 64'd4);
    chk("overflow.done", 64'(done_out), 64'd1);
    for (int i = 4; i >= 1; i--) pop_expect(32'(i), "full_pop");
    async_reset("rst_clear_err");

    step(1'b1, 1'b1, 32'hA5, "mix_push_a5");
    pop_expect(32'hA5, "mix_pop_a5");
    step(1'b1, 1'b1, 32'h5A, "mix_push_5a");
    step(1'b1, 1'b1, 32'h77, "mix_push_77");
    pop_expect(32'h77, "mix_pop_77");
    chk("mix.count1", 64'(count), 64'd1);
    async_reset("rst_pre_random");

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom, "random");
    end
    async_reset("rst_pre_stream");

    step(1'b1, 1'b1, 32'h01, "stream_push");
    step(1'b1, 1'b1, 32'h02, "stream_push");
    step(1'b1, 1'b1, 32'h03, "stream_push");
    trigger = 1'b1; push = 1'b1; write_value = 32'h44;
    rst = 1'b1;
    model_clear();
    #1;
    check_all("stream_rst_async");
    @(posedge clk);
    #1;
    check_all("stream_rst_edge");
    chk("stream_rst.nodone", 64'(done_out), 64'd0);
    rst = 1'b0;
    step(1'b1, 1'b1, 32'h99, "post_rst_push");
    pop_expect(32'h99, "post_rst_pop");
    step(1'b0, 1'b0, '0, "final_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
